// File: rtl/counter_seq_ctrl.sv
// ============================================================================
// Module   : counter_seq_ctrl
// Purpose  : Command-driven (START/PAUSE/RESUME/STOP) sequencer for a
//            multi-pass WIDTH-bit up-counter with a valid/ready command port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int RW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic [RW-1:0]    cmd_repeat,
  output logic [WIDTH-1:0] out,
  output logic [RW-1:0]    rep_left,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] c_op_start  = 2'b00;
  localparam logic [1:0] c_op_pause  = 2'b01;
  localparam logic [1:0] c_op_resume = 2'b10;
  localparam logic [1:0] c_op_stop   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_limit, w_limit;
  logic [RW-1:0]    r_rep, w_rep;
  logic             r_wrap, w_wrap;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             w_accept;
  logic             w_advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_limit <= '0;
      r_rep   <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_limit <= w_limit;
      r_rep   <= w_rep;
      r_wrap  <= w_wrap;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_accept  = cmd_valid && (r_state != S_LOAD);
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_limit   = r_limit;
    w_rep     = r_rep;
    w_wrap    = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_advance = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          case (cmd_op)
            c_op_start: begin
              w_state = S_LOAD;
              w_cnt   = '0;
              w_limit = cmd_limit;
              w_rep   = (cmd_repeat == '0) ? RW'(1) : cmd_repeat;
            end
            c_op_stop: begin
              w_state = S_IDLE;
              w_cnt   = '0;
              w_rep   = '0;
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      S_LOAD: w_state = S_RUN;
      S_RUN: begin
        w_advance = 1'b1;
        if (w_accept) begin
          case (cmd_op)
            c_op_pause: begin
              w_state   = S_PAUSE;
              w_advance = 1'b0;
            end
            c_op_stop: begin
              w_state   = S_IDLE;
              w_cnt     = '0;
              w_rep     = '0;
              w_advance = 1'b0;
            end
            default: w_err = 1'b1;
          endcase
        end
        // An illegal command still lets the counter advance this edge.
        if (w_advance) begin
          if (r_cnt < r_limit) begin
            w_cnt = r_cnt + WIDTH'(1);
          end else if (r_rep > RW'(1)) begin
            w_cnt  = '0;
            w_rep  = r_rep - RW'(1);
            w_wrap = 1'b1;
          end else begin
            w_state = S_DONE;
            w_rep   = '0;
            w_done  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (w_accept) begin
          case (cmd_op)
            c_op_resume: w_state = S_RUN;
            c_op_stop: begin
              w_state = S_IDLE;
              w_cnt   = '0;
              w_rep   = '0;
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state != S_LOAD);
  assign busy      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
  assign out       = r_cnt;
  assign rep_left  = r_rep;
  assign wrap      = r_wrap;
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Purpose  : Directed self-checking bench for counter_seq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_counter_seq_ctrl;

  localparam logic [1:0] c_start  = 2'b00;
  localparam logic [1:0] c_pause  = 2'b01;
  localparam logic [1:0] c_resume = 2'b10;
  localparam logic [1:0] c_stop   = 2'b11;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_limit;
  logic [3:0] cmd_repeat;
  logic [3:0] out;
  logic [3:0] rep_left;
  logic       busy;
  logic       wrap;
  logic       done;
  logic       err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  counter_seq_ctrl #(.WIDTH(4), .RW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_limit  (cmd_limit),
    .cmd_repeat (cmd_repeat),
    .out        (out),
    .rep_left   (rep_left),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic [1:0] op, input logic [3:0] lim, input logic [3:0] rep);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_limit  = lim;
    cmd_repeat = rep;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_limit = 4'd0; cmd_repeat = 4'd0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (out !== 4'd0) begin miss_cnt++; $display("FAIL rst_out got=%0d exp=0", out); end
    vec_cnt++; if (rep_left !== 4'd0) begin miss_cnt++; $display("FAIL rst_rep got=%0d exp=0", rep_left); end
    vec_cnt++; if ({busy, wrap, done, err} !== 4'b0000) begin miss_cnt++; $display("FAIL rst_flags got=%b exp=0000", {busy, wrap, done, err}); end
    vec_cnt++; if (cmd_ready !== 1'b1) begin miss_cnt++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_pass;
    int exp_out[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    issue(c_start, 4'd3, 4'd2);
    vec_cnt++; if (cmd_ready !== 1'b0) begin miss_cnt++; $display("FAIL t1_load_ready got=%b exp=0", cmd_ready); end
    vec_cnt++; if (busy !== 1'b1 || out !== 4'd0 || rep_left !== 4'd2) begin miss_cnt++; $display("FAIL t1_load busy=%b out=%0d rep=%0d exp 1/0/2", busy, out, rep_left); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec_cnt++; if (out !== 4'(exp_out[i])) begin miss_cnt++; $display("FAIL t1_out[%0d] got=%0d exp=%0d", i, out, exp_out[i]); end
      vec_cnt++; if (wrap !== (i == 4)) begin miss_cnt++; $display("FAIL t1_wrap[%0d] got=%b exp=%b", i, wrap, (i == 4)); end
      vec_cnt++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin miss_cnt++; $display("FAIL t1_run[%0d] done=%b ready=%b exp 0/1", i, done, cmd_ready); end
    end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b1 || out !== 4'd3 || busy !== 1'b0 || rep_left !== 4'd0) begin miss_cnt++; $display("FAIL t1_done done=%b out=%0d busy=%b rep=%0d exp 1/3/0/0", done, out, busy, rep_left); end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b0 || out !== 4'd3) begin miss_cnt++; $display("FAIL t1_hold done=%b out=%0d exp 0/3", done, out); end
  endtask

  task automatic test_pause_resume;
    issue(c_start, 4'd5, 4'd1);
    repeat (3) @(negedge clk);
    vec_cnt++; if (out !== 4'd2) begin miss_cnt++; $display("FAIL t2_pre got=%0d exp=2", out); end
    issue(c_pause, 4'd0, 4'd0);
    vec_cnt++; if (out !== 4'd2 || busy !== 1'b1 || err !== 1'b0) begin miss_cnt++; $display("FAIL t2_pause out=%0d busy=%b err=%b exp 2/1/0", out, busy, err); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec_cnt++; if (out !== 4'd2) begin miss_cnt++; $display("FAIL t2_frozen[%0d] got=%0d exp=2", i, out); end
    end
    issue(c_resume, 4'd0, 4'd0);
    vec_cnt++; if (out !== 4'd2 || err !== 1'b0) begin miss_cnt++; $display("FAIL t2_resume out=%0d err=%b exp 2/0", out, err); end
    for (int v = 3; v <= 5; v++) begin
      @(negedge clk);
      vec_cnt++; if (out !== 4'(v)) begin miss_cnt++; $display("FAIL t2_count got=%0d exp=%0d", out, v); end
    end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b1 || out !== 4'd5) begin miss_cnt++; $display("FAIL t2_done done=%b out=%0d exp 1/5", done, out); end
  endtask

  task automatic test_stop_priority;
    int wraps = 0;
    issue(c_start, 4'd15, 4'd3);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
    end
    vec_cnt++; if (wraps !== 2) begin miss_cnt++; $display("FAIL t3_wraps got=%0d exp=2", wraps); end
    vec_cnt++; if (out !== 4'd15 || rep_left !== 4'd1) begin miss_cnt++; $display("FAIL t3_last out=%0d rep=%0d exp 15/1", out, rep_left); end
    issue(c_stop, 4'd0, 4'd0);
    vec_cnt++; if (out !== 4'd0 || rep_left !== 4'd0 || busy !== 1'b0) begin miss_cnt++; $display("FAIL t3_stop out=%0d rep=%0d busy=%b exp 0/0/0", out, rep_left, busy); end
    vec_cnt++; if (done !== 1'b0 || wrap !== 1'b0 || cmd_ready !== 1'b1) begin miss_cnt++; $display("FAIL t3_pulse done=%b wrap=%b ready=%b exp 0/0/1", done, wrap, cmd_ready); end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b0 || out !== 4'd0) begin miss_cnt++; $display("FAIL t3_after done=%b out=%0d exp 0/0", done, out); end
  endtask

  task automatic test_illegal;
    issue(c_resume, 4'd0, 4'd0);
    vec_cnt++; if (err !== 1'b1 || out !== 4'd0 || busy !== 1'b0 || rep_left !== 4'd0) begin miss_cnt++; $display("FAIL t4_idle_resume err=%b out=%0d busy=%b rep=%0d exp 1/0/0/0", err, out, busy, rep_left); end
    @(negedge clk);
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL t4_err_width got=%b exp=0", err); end
    issue(c_start, 4'd9, 4'd2);
    repeat (2) @(negedge clk);
    vec_cnt++; if (out !== 4'd1) begin miss_cnt++; $display("FAIL t4_pre got=%0d exp=1", out); end
    issue(c_start, 4'd3, 4'd1);
    vec_cnt++; if (err !== 1'b1 || out !== 4'd2 || rep_left !== 4'd2 || busy !== 1'b1) begin miss_cnt++; $display("FAIL t4_run_start err=%b out=%0d rep=%0d busy=%b exp 1/2/2/1", err, out, rep_left, busy); end
    @(negedge clk);
    vec_cnt++; if (err !== 1'b0 || out !== 4'd3) begin miss_cnt++; $display("FAIL t4_next err=%b out=%0d exp 0/3", err, out); end
    repeat (6) @(negedge clk);
    vec_cnt++; if (out !== 4'd9 || wrap !== 1'b0) begin miss_cnt++; $display("FAIL t4_limit_kept out=%0d wrap=%b exp 9/0", out, wrap); end
    issue(c_stop, 4'd0, 4'd0);
    vec_cnt++; if (out !== 4'd0 || busy !== 1'b0) begin miss_cnt++; $display("FAIL t4_stop out=%0d busy=%b exp 0/0", out, busy); end
  endtask

  task automatic test_limit_zero;
    issue(c_start, 4'd0, 4'd0);
    vec_cnt++; if (rep_left !== 4'd1 || cmd_ready !== 1'b0) begin miss_cnt++; $display("FAIL t5_load rep=%0d ready=%b exp 1/0", rep_left, cmd_ready); end
    @(negedge clk);
    vec_cnt++; if (out !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin miss_cnt++; $display("FAIL t5_run out=%0d busy=%b done=%b exp 0/1/0", out, busy, done); end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b1 || out !== 4'd0 || busy !== 1'b0) begin miss_cnt++; $display("FAIL t5_done done=%b out=%0d busy=%b exp 1/0/0", done, out, busy); end
    issue(c_start, 4'd2, 4'd1);
    vec_cnt++; if (out !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin miss_cnt++; $display("FAIL t5_restart out=%0d busy=%b done=%b exp 0/1/0", out, busy, done); end
    for (int v = 0; v <= 2; v++) begin
      @(negedge clk);
      vec_cnt++; if (out !== 4'(v)) begin miss_cnt++; $display("FAIL t5_seq got=%0d exp=%0d", out, v); end
    end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b1 || out !== 4'd2) begin miss_cnt++; $display("FAIL t5_done2 done=%b out=%0d exp 1/2", done, out); end
    issue(c_start, 4'd0, 4'd2);
    @(negedge clk);
    vec_cnt++; if (out !== 4'd0 || rep_left !== 4'd2 || wrap !== 1'b0) begin miss_cnt++; $display("FAIL t5_z1 out=%0d rep=%0d wrap=%b exp 0/2/0", out, rep_left, wrap); end
    @(negedge clk);
    vec_cnt++; if (wrap !== 1'b1 || rep_left !== 4'd1 || out !== 4'd0) begin miss_cnt++; $display("FAIL t5_z2 wrap=%b rep=%0d out=%0d exp 1/1/0", wrap, rep_left, out); end
    @(negedge clk);
    vec_cnt++; if (done !== 1'b1 || wrap !== 1'b0 || rep_left !== 4'd0) begin miss_cnt++; $display("FAIL t5_z3 done=%b wrap=%b rep=%0d exp 1/0/0", done, wrap, rep_left); end
  endtask

  task automatic test_async_reset;
    issue(c_start, 4'd15, 4'd1);
    repeat (8) @(negedge clk);
    vec_cnt++; if (out !== 4'd7) begin miss_cnt++; $display("FAIL t6_pre got=%0d exp=7", out); end
    #2 reset = 1'b0;
    #1;
    vec_cnt++; if (out !== 4'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || rep_left !== 4'd0) begin miss_cnt++; $display("FAIL t6_async out=%0d ready=%b busy=%b rep=%0d exp 0/1/0/0", out, cmd_ready, busy, rep_left); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++; if (out !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin miss_cnt++; $display("FAIL t6_idle out=%0d busy=%b done=%b exp 0/0/0", out, busy, done); end
  endtask

  initial begin
    test_reset();
    test_two_pass();
    test_pause_resume();
    test_stop_priority();
    test_illegal();
    test_limit_zero();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit up-counter, built around the counter_n datapath style.
- Accepts START/PAUSE/RESUME/STOP commands over a valid/ready handshake.
- Runs the count 0..limit for a programmed number of passes, then signals completion.
- Sits between a host/test controller and counter display or timing logic, replacing free-running counter_n instances that have no start/stop control.

Parameters:
- WIDTH, 4: counter and limit width in bits.
- RW, 4: repeat-count width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  command code: 00 START, 01 PAUSE, 10 RESUME, 11 STOP.
- cmd_limit  in  WIDTH  terminal count; sampled on an accepted START only.
- cmd_repeat  in  RW  number of passes; sampled on an accepted START only; 0 is treated as 1.
- out  out  WIDTH  current count.
- rep_left  out  RW  passes remaining, including the current pass.
- busy  out  1  high in LOAD, RUN and PAUSE.
- wrap  out  1  one-cycle pulse when a non-final pass ends.
- done  out  1  one-cycle pulse on entry to DONE.
- err  out  1  one-cycle pulse when an illegal command is accepted.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, out=0, rep_left=0, limit register=0.
  - wrap=0, done=0, err=0, busy=0, cmd_ready=1.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = (state != LOAD), decoded combinationally from registered state.
  - Each command is acted on exactly once.
  - cmd_valid while cmd_ready=0 is not accepted; the host holds it.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE or DONE + START:
  - Go to LOAD; out<=0; latch limit; rep_left<=max(cmd_repeat,1).
  - LOAD lasts exactly one cycle; next edge goes to RUN with out unchanged (0).
- RUN, per edge with no accepted command:
  - out<limit: out<=out+1.
  - out==limit and rep_left>1: out<=0, rep_left<=rep_left-1, wrap=1 for one cycle.
  - out==limit and rep_left==1: go to DONE, rep_left<=0, done=1 for one cycle, out holds limit.
  - A full sequence occupies exactly (limit+1)*passes RUN cycles.
- PAUSE:
  - RUN + PAUSE: go to PAUSE; out and rep_left frozen; no advance on the accepting edge (the command wins over the increment, wrap and done).
  - PAUSE + RESUME: go to RUN; counting resumes from the frozen value on the following edge.
- STOP, legal in every state that can accept:
  - Go to IDLE, out<=0, rep_left<=0.
  - STOP takes priority over a same-edge wrap or done; neither pulse fires.
- Illegal commands (accepted, no state change, err=1 for one cycle):
  - START in RUN or PAUSE.
  - PAUSE outside RUN.
  - RESUME outside PAUSE.
  - An illegal command in RUN does not block that edge's normal advance.
- DONE holds out=limit and busy=0 until START (restart) or STOP (to IDLE, out<=0).
- limit=0: out stays 0; each RUN cycle ends a pass (wrap every cycle until the final pass).
- Arithmetic is unsigned; out never exceeds limit, so there is no natural WIDTH overflow.
- limit=2^WIDTH-1 runs the full range 0..15 (WIDTH=4).
- Reset asserted mid-operation forces the reset values immediately; in-flight commands are lost.

Test Plan:
1. Reset then START limit=3 repeat=2 -> one LOAD cycle with cmd_ready=0; out over 8 RUN cycles = 0,1,2,3,0,1,2,3; wrap on 4th→5th edge; done pulse once; out holds 3; busy=0.
2. START limit=5 repeat=1; PAUSE accepted when out=2 -> out stays 2 for 10 cycles; RESUME -> 3,4,5, then done.
3. START limit=15 repeat=3; STOP accepted at out==15 of final pass -> IDLE, out=0, no done, no wrap.
4. START during RUN, and RESUME in IDLE -> err pulses 1 cycle each; state, out and rep_left unchanged except the normal RUN advance.
5. START limit=0 repeat=0 -> treated as 1 pass; one RUN cycle with out=0, then done; then START limit=2 repeat=1 from DONE restarts with out sequence 0,1,2.
6. Drive reset=0 asynchronously mid-RUN at out=7 (between edges) -> out=0, state IDLE, cmd_ready=1 immediately, without waiting for a clk edge.
